// File: rtl/hsid_pkg.sv
// hsid_pkg: shared widths and reader FSM state encoding for the HSID engine
package hsid_pkg;
  localparam int HSID_WORD_WIDTH = 32;
  localparam int HSID_DATA_WIDTH = 16;
  localparam int HSID_BUFFER_LENGTH = 4;
  localparam int HSID_BANDS_WIDTH = 8;
  localparam int HSID_LIBRARY_WIDTH = 12;
  typedef enum logic [2:0] {
    IDLE,
    REQ_MEASURE,
    WAIT_MEASURE,
    REQ_LIBRARY,
    WAIT_LIBRARY,
    DONE
  } hsid_reader_state_t;
endpackage

// File: rtl/hsid_pair_fifo.sv
// hsid_pair_fifo: synchronous FIFO with full/empty flags and simultaneous push/pop
module hsid_pair_fifo #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = wr_ptr == rd_ptr;
  assign full = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
  assign do_pop = pop && !empty;
  // a pop in the same cycle frees the slot the push lands in
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/hsid_hsp_reader.sv
// hsid_hsp_reader: fetches measure/library band words over an OBI-style port
// and streams paired words with last-band/last-pixel markers through a FIFO
module hsid_hsp_reader import hsid_pkg::*; #(
  parameter int WORD_WIDTH = HSID_WORD_WIDTH,
  parameter int DATA_WIDTH = HSID_DATA_WIDTH,
  parameter int BUFFER_LENGTH = HSID_BUFFER_LENGTH,
  parameter int BANDS_WIDTH = HSID_BANDS_WIDTH,
  parameter int LIBRARY_WIDTH = HSID_LIBRARY_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     clear,
  input  logic [BANDS_WIDTH-1:0]   hsp_bands,
  input  logic [LIBRARY_WIDTH-1:0] hsp_library_size,
  input  logic [31:0]              measure_addr,
  input  logic [31:0]              library_addr,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic                     mem_gnt,
  input  logic                     mem_rvalid,
  input  logic [WORD_WIDTH-1:0]    mem_rdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_WIDTH-1:0]    out_measure,
  output logic [WORD_WIDTH-1:0]    out_library,
  output logic                     out_last_band,
  output logic                     out_last_pixel,
  output logic                     busy,
  output logic                     done
);
  localparam int PW = 2 * WORD_WIDTH + 2;
  hsid_reader_state_t state, next;
  logic [BANDS_WIDTH-1:0] wpp, w;
  logic [LIBRARY_WIDTH-1:0] lib_size, pix;
  logic [31:0] meas_base, lib_ptr;
  logic [WORD_WIDTH-1:0] hold, mask;
  logic [PW-1:0] din, dout;
  logic odd, pend, full, empty, push, fire, last_band, last_pixel;
  assign last_band = w == wpp - BANDS_WIDTH'(1);
  assign last_pixel = pix == lib_size - LIBRARY_WIDTH'(1);
  assign mask = (odd && last_band) ? {{(WORD_WIDTH-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}} : '1;
  // pend blocks new requests until any beat still in flight (even a stray one after clear) returns
  assign mem_req = !pend && (state == REQ_LIBRARY || (state == REQ_MEASURE && !full));
  assign mem_addr = !mem_req ? '0 : state == REQ_LIBRARY ? lib_ptr : meas_base + 32'({w, 2'b00});
  assign fire = mem_req && mem_gnt;
  assign push = state == WAIT_LIBRARY && mem_rvalid && !clear;
  assign din = {hold & mask, mem_rdata & mask, last_band, last_pixel};
  assign busy = state != IDLE;
  assign out_valid = !empty;
  assign {out_measure, out_library, out_last_band, out_last_pixel} = empty ? '0 : dout;
  hsid_pair_fifo #(.WIDTH(PW), .DEPTH(BUFFER_LENGTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .clear(clear),
    .push(push),
    .din(din),
    .pop(out_ready),
    .dout(dout),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    next = state;
    case (state)
      IDLE:         if (start) next = (hsp_bands == '0 || hsp_library_size == '0) ? DONE : !full ? REQ_MEASURE : IDLE;
      REQ_MEASURE:  if (fire) next = WAIT_MEASURE;
      WAIT_MEASURE: if (mem_rvalid) next = REQ_LIBRARY;
      REQ_LIBRARY:  if (fire) next = WAIT_LIBRARY;
      WAIT_LIBRARY: if (mem_rvalid) next = (last_band && last_pixel) ? DONE : REQ_MEASURE;
      DONE:         if (empty) next = IDLE;
      default:      next = IDLE;
    endcase
    if (clear) next = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      done <= 1'b0;
      pend <= 1'b0;
      w <= '0;
      pix <= '0;
      wpp <= '0;
      lib_size <= '0;
      odd <= 1'b0;
      meas_base <= '0;
      lib_ptr <= '0;
      hold <= '0;
    end else begin
      state <= next;
      done <= next == DONE && state != DONE;
      pend <= fire ? 1'b1 : mem_rvalid ? 1'b0 : pend;
      if (clear) begin
        w <= '0;
        pix <= '0;
        lib_ptr <= '0;
      end else begin
        if (state == IDLE && start) begin
          wpp <= {1'b0, hsp_bands[BANDS_WIDTH-1:1]} + BANDS_WIDTH'(hsp_bands[0]);
          lib_size <= hsp_library_size;
          odd <= hsp_bands[0];
          meas_base <= measure_addr;
          lib_ptr <= library_addr;
          w <= '0;
          pix <= '0;
        end
        if (state == WAIT_MEASURE && mem_rvalid) hold <= mem_rdata;
        if (state == REQ_LIBRARY && fire) lib_ptr <= lib_ptr + 32'd4;
        if (push) begin
          w <= last_band ? '0 : w + BANDS_WIDTH'(1);
          pix <= last_band ? pix + LIBRARY_WIDTH'(1) : pix;
        end
      end
    end
  end
endmodule

// File: tb/tb_hsid_hsp_reader.sv
// tb_hsid_hsp_reader: randomized scoreboard bench with a latency-randomized memory model
module tb_hsid_hsp_reader;
  logic clk = 0, rst_n = 0, start = 0, clear = 0;
  logic [7:0] hsp_bands = 0;
  logic [11:0] hsp_library_size = 0;
  logic [31:0] measure_addr = 0, library_addr = 0;
  logic mem_req, mem_gnt = 0, mem_rvalid = 0;
  logic [31:0] mem_addr, mem_rdata = 0;
  logic out_valid, out_ready = 0, out_last_band, out_last_pixel, busy, done;
  logic [31:0] out_measure, out_library;
  int checks = 0, errors = 0;
  logic [65:0] exp_pairs[$];
  logic [31:0] exp_addrs[$];
  bit ones_mode = 0, req_seen = 0, granted = 0, clear_d = 0, hold_chk = 0;
  int gmax = 0, rmin = 1, rmax = 1, ready_mode = 0;
  int grants = 0, req_cycles = 0, done_cnt = 0, gwait = 0, rv_left = 0;
  logic [31:0] req_addr = 0, gaddr = 0, rv_data = 0;
  logic [65:0] held = 0, mon_act = 0;

  hsid_hsp_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .hsp_bands(hsp_bands), .hsp_library_size(hsp_library_size),
    .measure_addr(measure_addr), .library_addr(library_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_measure(out_measure), .out_library(out_library),
    .out_last_band(out_last_band), .out_last_pixel(out_last_pixel),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return ones_mode ? 32'hFFFF_FFFF : {a[15:0] ^ 16'hC3A5, a[15:0] + 16'h1357};
  endfunction

  task automatic chk(string name, logic [65:0] act, logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // memory: grant after 0..gmax cycles, data 'rmin..rmax' cycles after the grant
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_gnt = 0; mem_rvalid = 0; granted = 0; rv_left = 0; req_seen = 0;
    end else begin
      mem_rvalid = 0;
      mem_gnt = 0;
      if (granted) begin
        rv_left = int'($urandom_range(rmax, rmin));
        rv_data = mem_word(gaddr);
        granted = 0;
      end
      if (rv_left > 0) begin
        rv_left--;
        if (rv_left == 0) begin mem_rvalid = 1; mem_rdata = rv_data; end
      end
      if (mem_req) begin
        req_cycles++;
        if (!req_seen) begin
          req_seen = 1; req_addr = mem_addr; gwait = int'($urandom_range(gmax, 0));
        end else chk("addr_stable", 66'(mem_addr), 66'(req_addr));
        if (gwait == 0) begin
          mem_gnt = 1; granted = 1; gaddr = mem_addr; req_seen = 0; grants++;
          if (exp_addrs.size() == 0) begin
            checks++; errors++;
            $display("FAIL req_extra: got addr %0h expected no request", mem_addr);
          end else chk("mem_addr", 66'(mem_addr), 66'(exp_addrs.pop_front()));
        end else gwait--;
      end else if (req_seen && !clear_d) begin
        checks++; errors++; req_seen = 0;
        $display("FAIL req_dropped: got mem_req 0 expected 1 until gnt");
      end else req_seen = 0;
      clear_d = clear;
    end
  end

  always @(posedge clk) begin
    #1;
    out_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? 1'($urandom_range(1, 0)) : 1'b0;
  end

  always @(negedge clk) begin
    mon_act = {out_measure, out_library, out_last_band, out_last_pixel};
    if (done) done_cnt++;
    if (hold_chk) begin
      chk("out_stable_valid", 66'(out_valid), 66'(1));
      chk("out_stable_data", mon_act, held);
    end
    hold_chk = out_valid && !out_ready && rst_n && !clear;
    held = mon_act;
    if (out_valid && out_ready && rst_n && !clear) begin
      if (exp_pairs.size() == 0) begin
        checks++; errors++;
        $display("FAIL pair_extra: got %0h expected none", mon_act);
      end else chk("pair", mon_act, exp_pairs.pop_front());
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic build_model(int bands, int lib, logic [31:0] mb, logic [31:0] lb);
    int wpp, k;
    logic [31:0] m, l;
    wpp = (bands + 1) / 2;
    k = 0;
    for (int p = 0; p < lib; p++)
      for (int i = 0; i < wpp; i++) begin
        m = mem_word(mb + 32'(4 * i));
        l = mem_word(lb + 32'(4 * k));
        if (bands % 2 == 1 && i == wpp - 1) begin m[31:16] = 0; l[31:16] = 0; end
        exp_addrs.push_back(mb + 32'(4 * i));
        exp_addrs.push_back(lb + 32'(4 * k));
        exp_pairs.push_back({m, l, i == wpp - 1, p == lib - 1});
        k++;
      end
  endtask

  task automatic start_job(int bands, int lib, logic [31:0] mb, logic [31:0] lb);
    hsp_bands = 8'(bands);
    hsp_library_size = 12'(lib);
    measure_addr = mb;
    library_addr = lb;
    build_model(bands, lib, mb, lb);
    done_cnt = 0;
    start = 1;
    cyc(1);
    start = 0;
  endtask

  task automatic finish_job(string name, int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin cyc(1); n++; end
    if (busy) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got busy 1 after %0d cycles expected 0", name, budget);
    end
    chk({name, "_done_cnt"}, 66'(done_cnt), 66'(1));
    chk({name, "_pairs_left"}, 66'(exp_pairs.size()), 66'(0));
    chk({name, "_addrs_left"}, 66'(exp_addrs.size()), 66'(0));
  endtask

  task automatic chk_zero(string name);
    chk({name, "_req"}, 66'(mem_req), 66'(0));
    chk({name, "_addr"}, 66'(mem_addr), 66'(0));
    chk({name, "_valid"}, 66'(out_valid), 66'(0));
    chk({name, "_data"}, {out_measure, out_library, out_last_band, out_last_pixel}, 66'(0));
    chk({name, "_busy"}, 66'(busy), 66'(0));
    chk({name, "_done"}, 66'(done), 66'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, g0, r0, b, l;
    cyc(3);
    chk_zero("reset");
    rst_n = 1;
    cyc(1);
    // zero-wait basic run plus first-output latency
    start_job(4, 2, 32'h1000, 32'h8000);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    chk("first_latency", 66'(n), 66'(4));
    cyc(1);
    finish_job("basic", 200);
    // odd band count with all-ones memory
    ones_mode = 1;
    ready_mode = 1;
    start_job(5, 2, 32'h2000, 32'h9000);
    finish_job("odd5", 400);
    ones_mode = 0;
    // back-pressure: FIFO fills then requests stop
    ready_mode = 2;
    cyc(1);
    g0 = grants;
    start_job(16, 10, 32'h3000, 32'hA000);
    cyc(20);
    chk("bp_grants", 66'(grants - g0), 66'(8));
    chk("bp_req", 66'(mem_req), 66'(0));
    chk("bp_valid", 66'(out_valid), 66'(1));
    ready_mode = 0;
    finish_job("backpressure", 2000);
    // random memory latency and consumer stalls
    gmax = 3; rmin = 1; rmax = 4; ready_mode = 1;
    for (int i = 0; i < 4; i++) begin
      b = i == 0 ? 4 : int'($urandom_range(9, 1));
      l = i == 0 ? 2 : int'($urandom_range(4, 1));
      start_job(b, l, 32'h4000 + 32'(i * 256), 32'hD000 + 32'(i * 1024));
      finish_job("random", 3000);
    end
    // clear in WAIT_LIBRARY with the beat still in flight
    gmax = 0; rmin = 3; rmax = 3; ready_mode = 2;
    cyc(1);
    g0 = grants;
    start_job(4, 2, 32'h5000, 32'hB000);
    n = 0;
    while (grants < g0 + 4 && n < 100) begin cyc(1); n++; end
    chk("clear_reach_grant", 66'(grants - g0), 66'(4));
    clear = 1;
    cyc(1);
    clear = 0;
    chk("clear_busy", 66'(busy), 66'(0));
    chk("clear_valid", 66'(out_valid), 66'(0));
    exp_pairs.delete();
    exp_addrs.delete();
    rmin = 1; rmax = 1; ready_mode = 0;
    cyc(1);
    start_job(3, 2, 32'h6000, 32'hC000);
    finish_job("after_clear", 400);
    // degenerate sizes go straight to DONE without memory traffic
    for (int i = 0; i < 2; i++) begin
      r0 = req_cycles;
      start_job(i == 0 ? 4 : 0, i == 0 ? 0 : 3, 32'h7000, 32'hE000);
      chk("zero_done", 66'(done), 66'(1));
      cyc(2);
      chk("zero_busy", 66'(busy), 66'(0));
      chk("zero_req", 66'(req_cycles - r0), 66'(0));
      chk("zero_done_cnt", 66'(done_cnt), 66'(1));
    end
    // reset in the middle of a run
    gmax = 1; rmax = 2; ready_mode = 1;
    start_job(8, 3, 32'h7100, 32'hF000);
    cyc(15);
    rst_n = 0;
    cyc(1);
    chk_zero("midrst");
    rst_n = 1;
    exp_pairs.delete();
    exp_addrs.delete();
    cyc(2);
    gmax = 0; rmax = 1;
    start_job(6, 2, 32'h7200, 32'hF800);
    finish_job("after_reset", 400);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
